// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Boot/program loader. It assembles a UART byte stream into DATA_W-bit
//   words and writes them into one of NUM_BANKS SRAMs. The core is held in
//   reset while a load is running.
//
//   Image format: <bank byte> <word0 bytes LE> <word1 bytes LE> ... <END_WORD>
//   When PROG_LOADER_CKSUM_EN is defined, END_WORD is followed by a trailer
//   word. The trailer must equal the modulo-2**DATA_W sum of all written words.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   prog_i       programming request (level); its rising edge starts a load
//   rx_dv_i      one-cycle byte-valid strobe from the UART receiver
//   rx_byte_i    received byte
//   we_o         one-cycle SRAM write strobe
//   bank_sel_o   one-hot target bank (valid with we_o)
//   addr_o       word address (valid with we_o)
//   wdata_o      write data (valid with we_o)
//   core_rst_no  core reset, active-low
//   busy_o       high while a load is in progress
//   err_o        sticky load error, cleared by the next load request
//
// Handshake: neither interface has backpressure. rx_dv_i marks one valid byte
// in every cycle where it is high, including back-to-back cycles, and every
// such byte is consumed in the cycle it arrives. we_o is a one-cycle pulse.
// The SRAM adapter must accept the write in that cycle, because there is no
// ready signal.
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 12,
  parameter int                 NUM_BANKS = 2,
  parameter logic [DATA_W-1:0]  END_WORD  = DATA_W'(32'h0000_0FFF)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  prog_i,
  input  logic                  rx_dv_i,
  input  logic [7:0]            rx_byte_i,
  output logic                  we_o,
  output logic [NUM_BANKS-1:0]  bank_sel_o,
  output logic [ADDR_W-1:0]     addr_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  core_rst_no,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [7:0] NUM_BANKS_B = 8'(NUM_BANKS);

`ifdef PROG_LOADER_CKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_BANK, S_LOAD, S_CKSUM, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_BANK, S_LOAD, S_DONE, S_ERR} state_t;
`endif

  state_t                 state_q, state_d;
  logic                   prog_prev_q, prog_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      word_q, word_d;
  logic [ADDR_W-1:0]      addr_cnt_q, addr_cnt_d;
  logic                   full_q, full_d;
  logic [BANK_W-1:0]      bank_q, bank_d;
`ifdef PROG_LOADER_CKSUM_EN
  logic [DATA_W-1:0]      sum_q, sum_d;
`endif

  logic                   we_q, we_d;
  logic [NUM_BANKS-1:0]   bank_sel_q, bank_sel_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic                   prog_rise;
  logic                   last_byte;
  logic                   to_err;
  logic [DATA_W-1:0]      word_shift;

  always_comb begin
    // Each byte enters at the top and moves down. After NBYTES bytes, the
    // first byte sits in bits [7:0], which gives little-endian assembly.
    word_shift = (word_q >> 8) | (DATA_W'(rx_byte_i) << (DATA_W - 8));
    last_byte  = (cnt_q == CNT_W'(NBYTES - 1));
    prog_rise  = prog_i & ~prog_prev_q;

    state_d      = state_q;
    prog_prev_d  = prog_i;
    cnt_d        = cnt_q;
    word_d       = word_q;
    addr_cnt_d   = addr_cnt_q;
    full_d       = full_q;
    bank_d       = bank_q;
`ifdef PROG_LOADER_CKSUM_EN
    sum_d        = sum_q;
`endif
    we_d         = 1'b0;
    bank_sel_d   = bank_sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    core_rst_n_d = core_rst_n_q;
    busy_d       = busy_q;
    err_d        = err_q;
    to_err       = 1'b0;

    case (state_q)
      S_IDLE: begin
        core_rst_n_d = 1'b1;
        busy_d       = 1'b0;
        if (prog_rise) begin
          state_d      = S_BANK;
          core_rst_n_d = 1'b0;
          busy_d       = 1'b1;
        end
      end

      S_BANK: begin
        if (!prog_i) begin
          to_err = 1'b1;
        end else if (rx_dv_i) begin
          if (rx_byte_i >= NUM_BANKS_B) begin
            to_err = 1'b1;
          end else begin
            state_d    = S_LOAD;
            bank_d     = rx_byte_i[BANK_W-1:0];
            cnt_d      = '0;
            addr_cnt_d = '0;
            full_d     = 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
            sum_d      = '0;
`endif
          end
        end
      end

      S_LOAD: begin
        if (!prog_i) begin
          to_err = 1'b1;
        end else if (rx_dv_i) begin
          word_d = word_shift;
          cnt_d  = last_byte ? '0 : cnt_q + 1'b1;
          if (last_byte) begin
            if (word_shift == END_WORD) begin
`ifdef PROG_LOADER_CKSUM_EN
              state_d      = S_CKSUM;
`else
              state_d      = S_DONE;
              core_rst_n_d = 1'b1;
              busy_d       = 1'b0;
`endif
            end else if (full_q) begin
              // The top address has already been written. Addresses never
              // wrap, so any further data word is an overflow.
              to_err = 1'b1;
            end else begin
              we_d       = 1'b1;
              bank_sel_d = NUM_BANKS'(1) << bank_q;
              addr_d     = addr_cnt_q;
              wdata_d    = word_shift;
`ifdef PROG_LOADER_CKSUM_EN
              sum_d      = sum_q + word_shift;
`endif
              if (addr_cnt_q == '1) full_d = 1'b1;
              else                  addr_cnt_d = addr_cnt_q + 1'b1;
            end
          end
        end
      end

`ifdef PROG_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (!prog_i) begin
          to_err = 1'b1;
        end else if (rx_dv_i) begin
          word_d = word_shift;
          cnt_d  = last_byte ? '0 : cnt_q + 1'b1;
          if (last_byte) begin
            if (word_shift == sum_q) begin
              state_d      = S_DONE;
              core_rst_n_d = 1'b1;
              busy_d       = 1'b0;
            end else begin
              to_err = 1'b1;
            end
          end
        end
      end
`endif

      S_DONE: begin
        state_d      = S_IDLE;
        core_rst_n_d = 1'b1;
        busy_d       = 1'b0;
      end

      S_ERR: begin
        err_d        = 1'b1;
        core_rst_n_d = 1'b0;
        busy_d       = 1'b0;
        if (prog_rise) begin
          state_d = S_BANK;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (to_err) begin
      state_d      = S_ERR;
      err_d        = 1'b1;
      core_rst_n_d = 1'b0;
      busy_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      prog_prev_q  <= 1'b0;
      cnt_q        <= '0;
      word_q       <= '0;
      addr_cnt_q   <= '0;
      full_q       <= 1'b0;
      bank_q       <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      sum_q        <= '0;
`endif
      we_q         <= 1'b0;
      bank_sel_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prog_prev_q  <= prog_prev_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      addr_cnt_q   <= addr_cnt_d;
      full_q       <= full_d;
      bank_q       <= bank_d;
`ifdef PROG_LOADER_CKSUM_EN
      sum_q        <= sum_d;
`endif
      we_q         <= we_d;
      bank_sel_q   <= bank_sel_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign we_o        = we_q;
  assign bank_sel_o  = bank_sel_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign core_rst_no = core_rst_n_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule
